clock_gate_ctrl: RTL



---
 rtl/clock_gate_pkg.sv | 15 +
 rtl/clock_gating.sv | 23 ++
 rtl/gate_timer.sv | 32 +++
 rtl/clock_gate_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/clock_gate_pkg.sv
// Shared types and helpers for the clock-gate sequencer.
package clock_gate_pkg;

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_IDLE = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } gate_state_t;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clock_gating.sv
// Glitch-free gating cell: enable is captured while CLK_IN is low, so the
// gated clock changes on the pulse after the edge that changed CLK_EN.
module clock_gating #(
    parameter bit INIT_VALUE = 1'b1
) (
    input  logic CLK_IN,
    input  logic RST,
    input  logic CLK_EN,
    output logic CLK_OUT
);

    logic en_q;

    always_ff @(negedge CLK_IN) begin
        if (RST)
            en_q <= INIT_VALUE;
        else
            en_q <= CLK_EN;
    end

    assign CLK_OUT = CLK_IN & en_q;

endmodule

// File: rtl/gate_timer.sv
// Loadable down-counter shared by the idle and wake intervals.
module gate_timer #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clock_gate_ctrl.sv
// Gated-clock sequencer: idles the domain off after a quiet period and wakes
// it on demand, acknowledging requesters only once the clock has settled.
module clock_gate_ctrl
    import clock_gate_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter bit INIT_ON     = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    input  logic             FORCE_ON,
    output logic [N_REQ-1:0] ACK,
    output logic             GATE_EN,
    output logic [1:0]       STATE,
    output logic             GCLK
);

    localparam int CNT_W = $clog2(max(IDLE_CYCLES, WAKE_CYCLES) + 1);
    localparam gate_state_t INIT_STATE = INIT_ON ? ST_ON : ST_OFF;

    gate_state_t      state_q, state_d;
    logic             gate_en_q;
    logic [N_REQ-1:0] ack_q;
    logic             any_req;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    assign any_req = (|REQ) | FORCE_ON;

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_ON: begin
                if (!any_req) begin
                    state_d  = ST_IDLE;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(IDLE_CYCLES - 1);
                end
            end
            ST_IDLE: begin
                // A request on the expiry edge keeps the clock running.
                if (any_req)
                    state_d = ST_ON;
                else if (tmr_zero)
                    state_d = ST_OFF;
                else
                    tmr_dec = 1'b1;
            end
            ST_OFF: begin
                if (any_req) begin
                    state_d  = ST_WAKE;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(WAKE_CYCLES - 1);
                end
            end
            ST_WAKE: begin
                if (tmr_zero)
                    state_d = ST_ON;
                else
                    tmr_dec = 1'b1;
            end
            default: state_d = INIT_STATE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= INIT_STATE;
            gate_en_q <= INIT_ON;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            gate_en_q <= (state_d != ST_OFF);
            ack_q     <= REQ & {N_REQ{state_d == ST_ON}};
        end
    end

    gate_timer #(.W(CNT_W)) u_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    clock_gating #(.INIT_VALUE(INIT_ON)) u_cg (
        .CLK_IN  (CLK),
        .RST     (RST),
        .CLK_EN  (gate_en_q),
        .CLK_OUT (GCLK)
    );

    assign ACK     = ack_q;
    assign GATE_EN = gate_en_q;
    assign STATE   = state_q;

endmodule
